// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared CPU constants (64-bit address/data width, legal LATENCY range) and the word type
package mem_responder_pkg;
  localparam int XLEN = 64;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;
  typedef logic [XLEN-1:0] word_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: memory bus -- data read (ren/raddr -> rvalid/rdata), write (wen/waddr/wdata), instruction read (iren/iraddr -> irvalid/irdata), oob_error
interface mem_responder_if;
  import mem_responder_pkg::*;
  logic mem_ren;
  word_t mem_raddr;
  logic mem_rvalid;
  word_t mem_rdata;
  logic mem_wen;
  word_t mem_waddr;
  word_t mem_wdata;
  logic mem_iren;
  word_t mem_iraddr;
  logic mem_irvalid;
  word_t mem_irdata;
  logic oob_error;
  modport master(
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_iren, mem_iraddr,
    input mem_rvalid, mem_rdata, mem_irvalid, mem_irdata, oob_error
  );
  modport slave(
    input mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_iren, mem_iraddr,
    output mem_rvalid, mem_rdata, mem_irvalid, mem_irdata, oob_error
  );
endinterface

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: LATENCY-stage valid+data shift register; ports clk, rst, in_valid/in_data -> out_valid/out_data (out_data holds while out_valid low)
module mem_resp_pipe
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  word_t in_data,
  output logic  out_valid,
  output word_t out_data
);
  logic [LATENCY-1:0] vld_q, vld_d;
  word_t [LATENCY-1:0] dat_q, dat_d;
  always_comb begin
    vld_d[0] = in_valid;
    dat_d[0] = in_data;
    for (int i = LATENCY - 1; i > 0; i--) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
    dat_d[LATENCY-1] = vld_d[LATENCY-1] ? dat_d[LATENCY-1] : dat_q[LATENCY-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end
  assign out_valid = vld_q[LATENCY-1];
  assign out_data = dat_q[LATENCY-1];
endmodule

// File: rtl/mem_responder.sv
// mem_responder: 2-read/1-write word memory with fixed-latency responses, write forwarding and sticky oob_error; ports clk, rst, bus (mem_responder_if.slave)
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int MEM_WORDS = 4096
) (
  input logic clk,
  input logic rst,
  mem_responder_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam word_t LIMIT = word_t'(MEM_WORDS) << 3;
  if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
    $error("mem_responder: LATENCY out of range");
  end
  if (MEM_WORDS != (1 << AW)) begin : g_bad_words
    $error("mem_responder: MEM_WORDS not a power of two");
  end
  word_t mem_q [MEM_WORDS];
  logic [AW-1:0] ridx, iidx, widx;
  logic ren, iren, wr_req, wr_en, roob, ioob, woob, oob_q, oob_d;
  word_t rd, ird;
  always_comb begin
    ridx = bus.mem_raddr[3 +: AW];
    iidx = bus.mem_iraddr[3 +: AW];
    widx = bus.mem_waddr[3 +: AW];
    roob = bus.mem_raddr >= LIMIT;
    ioob = bus.mem_iraddr >= LIMIT;
    woob = bus.mem_waddr >= LIMIT;
    ren = bus.mem_ren & ~rst;
    iren = bus.mem_iren & ~rst;
    wr_req = bus.mem_wen & ~rst;
    wr_en = wr_req & ~woob;
    rd = roob ? '0 : (wr_en && widx == ridx) ? bus.mem_wdata : mem_q[ridx];
    ird = ioob ? '0 : (wr_en && widx == iidx) ? bus.mem_wdata : mem_q[iidx];
    oob_d = oob_q | (ren & roob) | (iren & ioob) | (wr_req & woob);
  end
  always_ff @(posedge clk) if (wr_en) mem_q[widx] <= bus.mem_wdata;
  always_ff @(posedge clk) oob_q <= rst ? 1'b0 : oob_d;
  assign bus.oob_error = oob_q;
  mem_resp_pipe #(.LATENCY(LATENCY)) u_rpipe (
    .clk(clk), .rst(rst), .in_valid(ren), .in_data(rd),
    .out_valid(bus.mem_rvalid), .out_data(bus.mem_rdata)
  );
  mem_resp_pipe #(.LATENCY(LATENCY)) u_ipipe (
    .clk(clk), .rst(rst), .in_valid(iren), .in_data(ird),
    .out_valid(bus.mem_irvalid), .out_data(bus.mem_irdata)
  );
endmodule
